instr_reader_checker: RTL and testbench
=======================================

// Module: instr_reader_checker
// PURPOSE
//  Read-side initiator for the 32-entry instruction register. On start it walks read_pointer
//  over a programmed address window and captures each instruction_word. It recomputes the
//  expected result with a golden ALU and streams {addr, word, match} out on a valid/ready port.
//  It keeps pass/error tallies. Used as the self-checking drain in the lab testbench.
// PARAMETERS
//  DEPTH   32  entries in the instruction register (power of two)
//  ADDR_W  5   log2(DEPTH), must equal width of address_t
//  CNT_W   6   width of count input, holds 0..DEPTH
//  ERR_W   16  width of err_count/chk_count, saturating
// PORTS
//  clk               in   1          single clock, rising edge
//  reset             in   1          synchronous, active-high
//  start             in   1          pulse: latch first_addr/count, begin walk (ignored while busy)
//  first_addr        in   ADDR_W     first entry to read
//  count             in   CNT_W      number of entries to read, 0..DEPTH
//  read_pointer      out  ADDR_W     registered address into the instruction register
//  instruction_word  in   instruction_t  combinational read data for read_pointer
//  out_valid         out  1          output record valid
//  out_ready         in   1          sink accepts record when out_valid&&out_ready
//  out_addr          out  ADDR_W     address the record came from
//  out_instr         out  instruction_t  captured word
//  out_match         out  1          1 = stored result equals golden result
//  busy              out  1          high from accepted start until DONE
//  done              out  1          single-cycle pulse after last record handshakes
//  chk_count         out  ERR_W      records checked since last start (div-by-zero excluded)
//  err_count         out  ERR_W      mismatches since last start
// BEHAVIOUR
//  Reset: state IDLE; read_pointer=0; out_valid=0; out_*=0; busy=0; done=0; counters=0.
//  FSM IDLE->ADDR->CAPT->CHECK->OUT->(ADDR | DONE)->IDLE.
//   IDLE : start=1 -> latch first_addr into read_pointer, remaining=count, clear counters.
//          count==0 -> go directly to DONE (no records).
//   ADDR : read_pointer stable one cycle so that the combinational read settles.
//   CAPT : register instruction_word and read_pointer into the capture regs.
//   CHECK: golden ALU result registered; compare with captured result; set out_match.
//   OUT  : out_valid=1, out_* held stable until out_ready. On handshake:
//          read_pointer+1 (mod DEPTH), remaining-1; remaining==1 -> DONE else ADDR.
//   DONE : done=1 one cycle, busy=0 on next cycle, -> IDLE.
//  Per-entry latency start/advance -> out_valid is 3 cycles. Best-case throughput is 1 record per 4 cycles.
//  Address wrap: 31+1 -> 0. count=32 from any first_addr visits every entry exactly once.
//  Golden ALU, all operands signed 32-bit, result signed 64-bit:
//   PASSA=a; PASSB=b; ADD=a+b; SUB=a-b; MULT=a*b, full 64-bit product; DIV=a/b; MOD=a%b.
//   ADD, SUB and PASS results are sign-extended to 64 bits.
//   ZERO or unknown opcode: expected result 0.
//  DIV/MOD with b==0: out_match=1, record still emitted, excluded from chk_count and err_count.
//  Counters saturate at 2**ERR_W-1. They update in CHECK, so each record is counted once
//   even if OUT stalls.
//  start asserted while busy: ignored. out_ready while out_valid=0: no effect.
//  reset asserted mid-walk: immediate return to reset values; a pending record is dropped.
//  Counters are not cleared at DONE; they are cleared only by reset or the next accepted start.
// STRUCTURE
//  instr_register_pkg (shared): operand_t, opcode_t, address_t, instruction_t, Number_64.
//   Add to it: rd_state_t enum {IDLE,ADDR,CAPT,CHECK,OUT,DONE} and function golden_result().
//  Sub-module: instr_golden_alu — combinational (opcode, a, b) -> {result, div_zero}.
//   The checker instantiates it, and the scoreboard reuses it.
// TESTING
//  1 reset mid-OUT with out_ready=0 -> next cycle out_valid=0, busy=0, read_pointer=0,
//    err_count=0.
//  2 entries 0..2 = {ADD,5,-3,2},{SUB,5,7,-2},{PASSB,9,4,4}; start first=0 count=3;
//    out_ready=1 -> 3 records, all out_match=1, chk=3, err=0, done pulses once.
//  3 entry 7 = {MULT,3,4,16} as stored by a b*b writer -> golden 12, out_match=0, err_count=1.
//  4 first_addr=30, count=4 -> out_addr sequence 30,31,0,1. count=0 -> done with no out_valid.
//  5 entry 4 = {DIV,10,0,x} -> out_match=1, chk_count and err_count unchanged.
//    Hold out_ready=0 for 5 cycles -> out_* stable, record counted once.
//  6 start pulsed while busy -> ignored, walk completes with original count.

Source files
------------

// File: rtl/instr_reader_checker_pkg.sv
// Shared types for the instruction register and its read-side checker:
// operand/opcode/address/instruction types, the reader FSM state encoding
// and the golden result function used by the checker's ALU.
package instr_reader_checker_pkg;

  localparam int DEPTH  = 32;
  localparam int ADDR_W = 5;
  localparam int CNT_W  = 6;
  localparam int ERR_W  = 16;

  typedef logic signed [31:0]     operand_t;
  typedef logic signed [63:0]     Number_64;
  typedef logic [ADDR_W-1:0]      address_t;

  // 4-bit opcode so that encodings beyond MOD exist and map to a zero result
  typedef enum logic [3:0] {
    ZERO  = 4'd0,
    PASSA = 4'd1,
    PASSB = 4'd2,
    ADD   = 4'd3,
    SUB   = 4'd4,
    MULT  = 4'd5,
    DIV   = 4'd6,
    MOD   = 4'd7
  } opcode_t;

  typedef struct packed {
    opcode_t  opc;
    operand_t op_a;
    operand_t op_b;
    Number_64 rslt;
  } instruction_t;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR  = 3'd1,
    CAPT  = 3'd2,
    CHECK = 3'd3,
    OUT   = 3'd4,
    DONE  = 3'd5
  } rd_state_t;

  // Operands are widened to 64 bits first so MULT yields the full product and
  // DIV of the most negative value by -1 does not overflow.
  function automatic Number_64 golden_result(opcode_t opc, operand_t a, operand_t b);
    Number_64 w_a;
    Number_64 w_b;
    Number_64 w_r;
    w_a = {{32{a[31]}}, a};
    w_b = {{32{b[31]}}, b};
    w_r = 64'sd0;
    case (opc)
      PASSA:   w_r = w_a;
      PASSB:   w_r = w_b;
      ADD:     w_r = w_a + w_b;
      SUB:     w_r = w_a - w_b;
      MULT:    w_r = w_a * w_b;
      DIV:     w_r = (b == 32'sd0) ? 64'sd0 : (w_a / w_b);
      MOD:     w_r = (b == 32'sd0) ? 64'sd0 : (w_a % w_b);
      default: w_r = 64'sd0;
    endcase
    return w_r;
  endfunction

endpackage

// File: rtl/instr_reader_checker_alu.sv
// Golden ALU: purely combinational reference result for one instruction,
// plus a flag marking division/modulo by zero (result is meaningless then).
module instr_golden_alu
  import instr_reader_checker_pkg::*;
(
  input  opcode_t  i_opc,
  input  operand_t i_a,
  input  operand_t i_b,
  output Number_64 o_result,
  output logic     o_div_zero
);

  assign o_result   = golden_result(i_opc, i_a, i_b);
  assign o_div_zero = ((i_opc == DIV) || (i_opc == MOD)) && (i_b == 32'sd0);

endmodule

// File: rtl/instr_reader_checker.sv
// Read-side checker for the instruction register: walks a programmed address
// window, captures each word, compares its stored result against the golden
// ALU and streams {addr, word, match} records over a valid/ready port while
// keeping saturating check/error tallies.
module instr_reader_checker
  import instr_reader_checker_pkg::*;
#(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 6,
  parameter int ERR_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] first_addr,
  input  logic [CNT_W-1:0]  count,
  output logic [ADDR_W-1:0] read_pointer,
  input  instruction_t      instruction_word,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_addr,
  output instruction_t      out_instr,
  output logic              out_match,
  output logic              busy,
  output logic              done,
  output logic [ERR_W-1:0]  chk_count,
  output logic [ERR_W-1:0]  err_count
);

  rd_state_t         r_state;
  logic [ADDR_W-1:0] r_read_pointer;
  logic [CNT_W-1:0]  r_remaining;
  logic              r_out_valid;
  logic [ADDR_W-1:0] r_out_addr;
  instruction_t      r_out_instr;
  logic              r_out_match;
  logic              r_busy;
  logic              r_done;
  logic [ERR_W-1:0]  r_chk_count;
  logic [ERR_W-1:0]  r_err_count;

  Number_64          w_golden;
  logic              w_div_zero;
  logic              w_mismatch;

  // The captured word doubles as the output record, so the ALU checks out_instr
  instr_golden_alu u_alu (
    .i_opc      (r_out_instr.opc),
    .i_a        (r_out_instr.op_a),
    .i_b        (r_out_instr.op_b),
    .o_result   (w_golden),
    .o_div_zero (w_div_zero)
  );

  assign w_mismatch = (r_out_instr.rslt != w_golden);

  // Reader FSM: address walk, capture, check, output handshake and tallies
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= IDLE;
      r_read_pointer <= {ADDR_W{1'b0}};
      r_remaining    <= {CNT_W{1'b0}};
      r_out_valid    <= 1'b0;
      r_out_addr     <= {ADDR_W{1'b0}};
      r_out_instr    <= '0;
      r_out_match    <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_chk_count    <= {ERR_W{1'b0}};
      r_err_count    <= {ERR_W{1'b0}};
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_read_pointer <= first_addr;
            r_remaining    <= count;
            r_chk_count    <= {ERR_W{1'b0}};
            r_err_count    <= {ERR_W{1'b0}};
            r_busy         <= 1'b1;
            if (count == {CNT_W{1'b0}}) begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_state <= ADDR;
            end
          end else begin
            r_state <= IDLE;
          end
        end
        // read_pointer held one cycle so the combinational read settles
        ADDR: r_state <= CAPT;
        CAPT: begin
          r_out_addr  <= r_read_pointer;
          r_out_instr <= instruction_word;
          r_state     <= CHECK;
        end
        // Counters move here so a stalled record is tallied exactly once
        CHECK: begin
          if (w_div_zero) begin
            r_out_match <= 1'b1;
          end else begin
            r_out_match <= ~w_mismatch;
            if (r_chk_count != {ERR_W{1'b1}}) begin
              r_chk_count <= r_chk_count + {{(ERR_W-1){1'b0}}, 1'b1};
            end
            if (w_mismatch && (r_err_count != {ERR_W{1'b1}})) begin
              r_err_count <= r_err_count + {{(ERR_W-1){1'b0}}, 1'b1};
            end
          end
          r_out_valid <= 1'b1;
          r_state     <= OUT;
        end
        OUT: begin
          if (out_ready) begin
            r_out_valid    <= 1'b0;
            r_read_pointer <= r_read_pointer + {{(ADDR_W-1){1'b0}}, 1'b1};
            r_remaining    <= r_remaining - {{(CNT_W-1){1'b0}}, 1'b1};
            if (r_remaining == {{(CNT_W-1){1'b0}}, 1'b1}) begin
              r_done  <= 1'b1;
              r_state <= DONE;
            end else begin
              r_state <= ADDR;
            end
          end else begin
            r_state <= OUT;
          end
        end
        DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= IDLE;
        end
        default: begin
          r_out_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign read_pointer = r_read_pointer;
  assign out_valid    = r_out_valid;
  assign out_addr     = r_out_addr;
  assign out_instr    = r_out_instr;
  assign out_match    = r_out_match;
  assign busy         = r_busy;
  assign done         = r_done;
  assign chk_count    = r_chk_count;
  assign err_count    = r_err_count;

endmodule

// File: tb/tb_instr_reader_checker.sv
// Directed bench for instr_reader_checker: a behavioural instruction register
// feeds the reader; expected records and tallies are hand-computed per case.
module tb_instr_reader_checker;
  import instr_reader_checker_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic         start;
  logic [4:0]   first_addr;
  logic [5:0]   count;
  logic [4:0]   read_pointer;
  instruction_t instruction_word;
  logic         out_valid;
  logic         out_ready;
  logic [4:0]   out_addr;
  instruction_t out_instr;
  logic         out_match;
  logic         busy;
  logic         done;
  logic [15:0]  chk_count;
  logic [15:0]  err_count;

  instruction_t mem [32];
  assign instruction_word = mem[read_pointer];

  instr_reader_checker dut (
    .clk              (clk),
    .reset            (reset),
    .start            (start),
    .first_addr       (first_addr),
    .count            (count),
    .read_pointer     (read_pointer),
    .instruction_word (instruction_word),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_addr         (out_addr),
    .out_instr        (out_instr),
    .out_match        (out_match),
    .busy             (busy),
    .done             (done),
    .chk_count        (chk_count),
    .err_count        (err_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  logic [4:0] rec_addr [$];
  logic       rec_match [$];
  int         done_pulses = 0;
  int         valid_cycles = 0;

  // Record monitor, sampled mid-cycle away from the active edge
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      rec_addr.push_back(out_addr);
      rec_match.push_back(out_match);
    end
    if (out_valid) valid_cycles++;
    if (done) done_pulses++;
  end

  task automatic check_eq(input string tag, input logic [131:0] obs, input logic [131:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic instruction_t mk(opcode_t o, int a, int b, longint r);
    instruction_t t;
    t.opc  = o;
    t.op_a = a;
    t.op_b = b;
    t.rslt = r;
    return t;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    rec_addr.delete();
    rec_match.delete();
    done_pulses  = 0;
    valid_cycles = 0;
  endtask

  task automatic do_start(input logic [4:0] f, input logic [5:0] c);
    first_addr = f;
    count      = c;
    start      = 1'b1;
    tick(1);
    start      = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      seen = done;
    end
    check_eq(tag, seen, 1'b1);
    tick(1);
  endtask

  task automatic wait_valid(input string tag, input int budget);
    bit seen;
    seen = 1'b0;
    for (int k = 0; k < budget && !seen; k++) begin
      @(negedge clk);
      seen = out_valid;
    end
    check_eq(tag, seen, 1'b1);
  endtask

  task automatic check_addrs(input string tag, input int exp_n, input int first);
    check_eq({tag, "_nrec"}, rec_addr.size(), exp_n);
    for (int i = 0; i < exp_n; i++) begin
      if (i < rec_addr.size()) begin
        check_eq({tag, "_addr"}, rec_addr[i], (first + i) % 32);
      end
    end
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    first_addr = 5'd0;
    count      = 6'd0;
    out_ready  = 1'b0;
    for (int i = 0; i < 32; i++) mem[i] = mk(ZERO, 0, 0, 64'sd0);

    // Reset state
    tick(3);
    check_eq("rst_valid", out_valid, 1'b0);
    check_eq("rst_busy", busy, 1'b0);
    check_eq("rst_done", done, 1'b0);
    check_eq("rst_rp", read_pointer, 5'd0);
    check_eq("rst_chk", chk_count, 16'd0);
    check_eq("rst_err", err_count, 16'd0);
    reset = 1'b0;
    tick(1);

    // Test 1: reset in the middle of a stalled OUT
    mem[7] = mk(MULT, 3, 4, 64'sd16);
    mem[8] = mk(ADD, 1, 1, 64'sd2);
    out_ready = 1'b0;
    do_start(5'd7, 6'd2);
    wait_valid("t1_valid_seen", 20);
    check_eq("t1_pre_err", err_count, 16'd1);
    tick(2);
    reset = 1'b1;
    tick(1);
    check_eq("t1_valid", out_valid, 1'b0);
    check_eq("t1_busy", busy, 1'b0);
    check_eq("t1_rp", read_pointer, 5'd0);
    check_eq("t1_err", err_count, 16'd0);
    reset = 1'b0;
    tick(1);

    // Test 2: three matching records
    mem[0] = mk(ADD, 5, -3, 64'sd2);
    mem[1] = mk(SUB, 5, 7, -64'sd2);
    mem[2] = mk(PASSB, 9, 4, 64'sd4);
    clear_mon();
    out_ready = 1'b1;
    do_start(5'd0, 6'd3);
    wait_done("t2_done_seen", 100);
    check_addrs("t2", 3, 0);
    for (int i = 0; i < 3; i++) begin
      if (i < rec_match.size()) check_eq("t2_match", rec_match[i], 1'b1);
    end
    check_eq("t2_chk", chk_count, 16'd3);
    check_eq("t2_err", err_count, 16'd0);
    check_eq("t2_done_pulses", done_pulses, 1);
    check_eq("t2_busy", busy, 1'b0);

    // Test 3: corrupted MULT result, plus start-to-valid latency
    clear_mon();
    do_start(5'd7, 6'd1);
    tick(2);
    check_eq("t3_lat_early", out_valid, 1'b0);
    tick(1);
    check_eq("t3_lat_valid", out_valid, 1'b1);
    check_eq("t3_addr", out_addr, 5'd7);
    check_eq("t3_match", out_match, 1'b0);
    check_eq("t3_err", err_count, 16'd1);
    check_eq("t3_chk", chk_count, 16'd1);
    wait_done("t3_done_seen", 50);
    check_eq("t3_nrec", rec_addr.size(), 1);

    // Test 4: address wrap, then count of zero
    mem[30] = mk(ADD, 1, 1, 64'sd2);
    mem[31] = mk(PASSA, -7, 0, -64'sd7);
    clear_mon();
    do_start(5'd30, 6'd4);
    wait_done("t4_done_seen", 100);
    check_addrs("t4", 4, 30);
    check_eq("t4_chk", chk_count, 16'd4);
    check_eq("t4_err", err_count, 16'd0);
    clear_mon();
    do_start(5'd3, 6'd0);
    wait_done("t4z_done_seen", 10);
    check_eq("t4z_valid_cycles", valid_cycles, 0);
    check_eq("t4z_done_pulses", done_pulses, 1);
    check_eq("t4z_chk", chk_count, 16'd0);

    // Test 5: divide by zero and a mismatch, each stalled for 5 cycles
    mem[4] = mk(DIV, 10, 0, 64'sd0);
    mem[5] = mk(SUB, 1, 2, 64'sd5);
    clear_mon();
    out_ready = 1'b0;
    do_start(5'd4, 6'd2);
    wait_valid("t5_valid_seen", 20);
    for (int k = 0; k < 5; k++) begin
      tick(1);
      check_eq("t5_hold_valid", out_valid, 1'b1);
      check_eq("t5_hold_addr", out_addr, 5'd4);
      check_eq("t5_hold_instr", out_instr, mk(DIV, 10, 0, 64'sd0));
      check_eq("t5_hold_match", out_match, 1'b1);
    end
    check_eq("t5_dz_chk", chk_count, 16'd0);
    check_eq("t5_dz_err", err_count, 16'd0);
    out_ready = 1'b1;
    tick(1);
    out_ready = 1'b0;
    wait_valid("t5_valid2_seen", 20);
    tick(5);
    check_eq("t5_mm_addr", out_addr, 5'd5);
    check_eq("t5_mm_match", out_match, 1'b0);
    check_eq("t5_mm_chk", chk_count, 16'd1);
    check_eq("t5_mm_err", err_count, 16'd1);
    out_ready = 1'b1;
    wait_done("t5_done_seen", 50);
    check_addrs("t5", 2, 4);
    check_eq("t5_end_chk", chk_count, 16'd1);
    check_eq("t5_end_err", err_count, 16'd1);

    // Test 6: start while busy is ignored
    clear_mon();
    do_start(5'd0, 6'd3);
    tick(2);
    do_start(5'd20, 6'd1);
    wait_done("t6_done_seen", 100);
    check_addrs("t6", 3, 0);
    check_eq("t6_chk", chk_count, 16'd3);
    check_eq("t6_done_pulses", done_pulses, 1);
    tick(3);
    check_eq("t6_idle_busy", busy, 1'b0);
    check_eq("t6_no_extra", rec_addr.size(), 3);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
